// File: rtl/add_serial_arb.sv
// add_serial_arb: two-requester round-robin arbiter in front of a bit-serial
// adder. The winner's operands are latched at the grant edge and added LSB
// first over WIDTH cycles. The registered sum appears on 'out' in the cycle
// in which that requester's done pulse is high.
// Optional feature macro: ADD_SERIAL_ARB_COUT_EN adds a registered carry-out
// port 'cout'.
module add_serial_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] out
`ifdef ADD_SERIAL_ARB_COUT_EN
  ,
  output logic             cout
`endif
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             owner_q, owner_d;
  logic             ptr_q, ptr_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             sum_bit;
  logic             carry_nxt;
  logic             sel;
`ifdef ADD_SERIAL_ARB_COUT_EN
  logic             cout_q, cout_d;
`endif

  // Next-state logic: arbitration in IDLE, one sum bit per ADD cycle, and a
  // single DONE cycle. The pointer flips to the unserved requester when the
  // operation finishes.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    out_d     = out_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gnt0_d    = 1'b0;
    gnt1_d    = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    sel       = (req0 && req1) ? ptr_q : req1;
`ifdef ADD_SERIAL_ARB_COUT_EN
    cout_d    = cout_q;
`endif
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          owner_d = sel;
          a_d     = sel ? a1 : a0;
          b_d     = sel ? b1 : b0;
          carry_d = 1'b0;
          cnt_d   = '0;
          state_d = ADD;
          gnt0_d  = ~sel;
          gnt1_d  = sel;
        end
      end
      ADD: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        res_d   = {sum_bit, res_q[WIDTH-1:1]};
        carry_d = carry_nxt;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          out_d   = {sum_bit, res_q[WIDTH-1:1]};
          done0_d = ~owner_q;
          done1_d = owner_q;
          ptr_d   = ~owner_q;
`ifdef ADD_SERIAL_ARB_COUT_EN
          cout_d  = carry_nxt;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      owner_q <= 1'b0;
      ptr_q   <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
`ifdef ADD_SERIAL_ARB_COUT_EN
      cout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
`ifdef ADD_SERIAL_ARB_COUT_EN
      cout_q  <= cout_d;
`endif
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = (state_q != IDLE);
  assign out   = out_q;
`ifdef ADD_SERIAL_ARB_COUT_EN
  assign cout  = cout_q;
`endif

endmodule

// File: tb/tb_add_serial_arb.sv
// Directed testbench for add_serial_arb (WIDTH=8). Each scenario task drives
// its stimulus and checks the outputs against hand-computed values.
module tb_add_serial_arb;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic             gnt0, gnt1, done0, done1, busy;
  logic [WIDTH-1:0] out;
`ifdef ADD_SERIAL_ARB_COUT_EN
  logic             cout;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  add_serial_arb #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .req0  (req0),
    .req1  (req1),
    .a0    (a0),
    .b0    (b0),
    .a1    (a1),
    .b1    (b1),
    .gnt0  (gnt0),
    .gnt1  (gnt1),
    .done0 (done0),
    .done1 (done1),
    .busy  (busy),
    .out   (out)
`ifdef ADD_SERIAL_ARB_COUT_EN
    ,
    .cout  (cout)
`endif
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req0 = 1'b0;
    req1 = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Single requester-0 operation: grant, WIDTH cycles of ADD, done with sum.
  task automatic run_req0_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic [WIDTH-1:0] prev, input logic [WIDTH-1:0] exp_sum,
                             input logic exp_cout);
    a0 = a; b0 = b; req0 = 1'b1;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin
      bad++;
      $display("[TB] FAIL grant0: gnt0=%b gnt1=%b busy=%b required 1 0 1", gnt0, gnt1, busy);
    end
    req0 = 1'b0;
    for (int i = 1; i <= WIDTH; i++) begin
      tick();
      if (i < WIDTH) begin
        total++;
        if (done0 !== 1'b0 || gnt0 !== 1'b0 || out !== prev) begin
          bad++;
          $display("[TB] FAIL add_cycle%0d: done0=%b gnt0=%b out=%h required 0 0 %h",
                   i, done0, gnt0, out, prev);
        end
      end
    end
    total++;
    if (done0 !== 1'b1 || done1 !== 1'b0 || out !== exp_sum) begin
      bad++;
      $display("[TB] FAIL done0: done0=%b done1=%b out=%h required 1 0 %h",
               done0, done1, out, exp_sum);
    end
`ifdef ADD_SERIAL_ARB_COUT_EN
    total++;
    if (cout !== exp_cout) begin
      bad++;
      $display("[TB] FAIL cout: got %b required %b", cout, exp_cout);
    end
`else
    if (exp_cout === 1'bx) $display("[TB] unexpected unknown carry");
`endif
    tick();
    total++;
    if (busy !== 1'b0 || done0 !== 1'b0 || out !== exp_sum) begin
      bad++;
      $display("[TB] FAIL back_idle: busy=%b done0=%b out=%h required 0 0 %h",
               busy, done0, out, exp_sum);
    end
  endtask

  task automatic test_reset();
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    do_reset();
    total++;
    if (busy !== 1'b0 || out !== 8'h00 || gnt0 !== 1'b0 || gnt1 !== 1'b0 ||
        done0 !== 1'b0 || done1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset: busy=%b out=%h gnt=%b%b done=%b%b required all 0",
               busy, out, gnt0, gnt1, done0, done1);
    end
  endtask

  task automatic test_basic();
    run_req0_op(8'h5A, 8'h3C, 8'h00, 8'h96, 1'b0);
  endtask

  task automatic test_overflow();
    run_req0_op(8'hFF, 8'h01, 8'h96, 8'h00, 1'b1);
  endtask

  task automatic test_simultaneous();
    do_reset();
    a0 = 8'h10; b0 = 8'h0E; a1 = 8'h01; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    total++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sim_first: gnt0=%b gnt1=%b required 1 0", gnt0, gnt1);
    end
    req0 = 1'b0;
    for (int i = 0; i < WIDTH; i++) tick();
    total++;
    if (done0 !== 1'b1 || out !== 8'h1E) begin
      bad++;
      $display("[TB] FAIL sim_done0: done0=%b out=%h required 1 1e", done0, out);
    end
    tick();
    tick();
    total++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sim_second: gnt0=%b gnt1=%b required 0 1", gnt0, gnt1);
    end
    req1 = 1'b0;
    for (int i = 0; i < WIDTH; i++) tick();
    total++;
    if (done1 !== 1'b1 || done0 !== 1'b0 || out !== 8'h03) begin
      bad++;
      $display("[TB] FAIL sim_done1: done1=%b done0=%b out=%h required 1 0 03",
               done1, done0, out);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int last;
    int found;
    do_reset();
    a0 = 8'h01; b0 = 8'h01; a1 = 8'h02; b1 = 8'h02;
    req0 = 1'b1; req1 = 1'b1;
    last = 0;
    for (int g = 0; g < 4; g++) begin
      found = 0;
      for (int t = 0; t < 20 && found == 0; t++) begin
        tick();
        if (gnt0 === 1'b1 || gnt1 === 1'b1) found = 1;
      end
      total++;
      if (found == 0) begin
        bad++;
        $display("[TB] FAIL b2b_timeout: grant %0d got none required one", g);
      end else begin
        if (gnt0 !== ((g % 2) == 0) || gnt1 !== ((g % 2) == 1)) begin
          bad++;
          $display("[TB] FAIL b2b_order: grant %0d gnt0=%b gnt1=%b required requester %0d",
                   g, gnt0, gnt1, g % 2);
        end
        if (g > 0) begin
          total++;
          if (cyc - last !== WIDTH + 2) begin
            bad++;
            $display("[TB] FAIL b2b_period: got %0d required %0d", cyc - last, WIDTH + 2);
          end
        end
        last = cyc;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    found = 0;
    for (int t = 0; t < 20 && found == 0; t++) begin
      tick();
      if (busy === 1'b0) found = 1;
    end
    total++;
    if (found == 0 || out !== 8'h04) begin
      bad++;
      $display("[TB] FAIL b2b_end: idle=%0d out=%h required 1 04", found, out);
    end
  endtask

  task automatic test_reset_mid_add();
    int seen;
    a0 = 8'h11; b0 = 8'h22; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || out !== 8'h00 || done0 !== 1'b0) begin
      bad++;
      $display("[TB] FAIL mid_reset: busy=%b out=%h done0=%b required 0 00 0", busy, out, done0);
    end
    seen = 0;
    for (int i = 0; i < WIDTH + 2; i++) begin
      tick();
      if (done0 === 1'b1 || done1 === 1'b1) seen = 1;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("[TB] FAIL abort_done: got done pulse required none");
    end
    run_req0_op(8'h03, 8'h04, 8'h00, 8'h07, 1'b0);
  endtask

  task automatic test_operand_change();
    int stray;
    a0 = 8'h5A; b0 = 8'h3C; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    req1 = 1'b1;
    a1 = 8'h77; b1 = 8'h77;
    tick(); tick();
    a0 = 8'h00;
    stray = 0;
    for (int i = 2; i < WIDTH; i++) begin
      tick();
      if (gnt1 === 1'b1) stray = 1;
    end
    req1 = 1'b0;
    total++;
    if (done0 !== 1'b1 || out !== 8'h96 || stray !== 0) begin
      bad++;
      $display("[TB] FAIL op_change: done0=%b out=%h stray_gnt1=%0d required 1 96 0",
               done0, out, stray);
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    test_reset();
    test_basic();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid_add();
    test_operand_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Grants and completions to the two requesters must be mutually exclusive.
  always @(negedge clk) begin
    if (!rst) begin
      if ((gnt0 && gnt1) || (done0 && done1)) begin
        total++;
        bad++;
        $display("[TB] FAIL exclusive: gnt=%b%b done=%b%b required one-hot", gnt0, gnt1, done0, done1);
      end
    end
  end

endmodule
